// File: rtl/vdp_cpu_port_if.sv
// VRAM request/grant bus between the VDP CPU port (master) and the VRAM
// arbiter (slave). Address and write qualifier are sampled by the arbiter
// in the grant cycle; read data returns the cycle after a read grant.
interface vdp_cpu_port_if #(
  parameter int VRAM_AW = 14
);
  logic               vram_req;
  logic               vram_grant;
  logic [VRAM_AW-1:0] vram_addr;
  logic               vram_we;
  logic [7:0]         vram_wdata;
  logic [7:0]         vram_rdata;

  modport master (
    output vram_req,
    output vram_addr,
    output vram_we,
    output vram_wdata,
    input  vram_grant,
    input  vram_rdata
  );

  modport slave (
    input  vram_req,
    input  vram_addr,
    input  vram_we,
    input  vram_wdata,
    output vram_grant,
    output vram_rdata
  );
endinterface

// File: rtl/vdp_cpu_port.sv
// VDP CPU port: decodes Z80 data-port (0xBE) and control-port (0xBF)
// accesses into VRAM writes / read-ahead fetches, CRAM writes and VDP
// register writes. VRAM traffic uses a request/grant handshake.
//
// Build option: define GG_CRAM_EN for Game Gear CRAM (12-bit words built
// from an even/odd byte pair). Left undefined, the SMS 6-bit CRAM is used.
module vdp_cpu_port #(
  parameter int VRAM_AW = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_wr,
  input  logic                  cpu_rd,
  input  logic                  cpu_port,
  input  logic [7:0]            cpu_din,
  output logic [7:0]            cpu_dout,
  output logic                  busy,
  input  logic [7:0]            status_in,
  output logic                  status_rd,
  vdp_cpu_port_if.master        vram,
  output logic                  cram_we,
  output logic [4:0]            cram_addr,
  output logic [11:0]           cram_wdata,
  output logic                  reg_we,
  output logic [3:0]            reg_addr,
  output logic [7:0]            reg_wdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [VRAM_AW-1:0] addr_q, addr_d;
  logic [1:0]         code_q, code_d;
  logic               flag_q, flag_d;
  logic [7:0]         rbuf_q, rbuf_d;
  logic [VRAM_AW-1:0] vaddr_q, vaddr_d;
  logic [7:0]         vwdata_q, vwdata_d;
  logic               vreq_q, vreq_d;
  logic               vwe_q, vwe_d;
  logic               busy_q, busy_d;
  logic               reg_we_q, reg_we_d;
  logic [3:0]         reg_addr_q, reg_addr_d;
  logic [7:0]         reg_wdata_q, reg_wdata_d;
  logic               cram_we_q, cram_we_d;
  logic [4:0]         cram_addr_q, cram_addr_d;
  logic [11:0]        cram_wdata_q, cram_wdata_d;
`ifdef GG_CRAM_EN
  logic [7:0]         latch_q, latch_d;
`endif

  logic               idle_s;
  logic [VRAM_AW-1:0] addr_inc_s;
  logic [13:0]        hi_lo_s;
  logic [VRAM_AW-1:0] new_addr_s;

  assign idle_s     = (state_q == IDLE);
  assign addr_inc_s = addr_q + VRAM_AW'(1);
  assign hi_lo_s    = {cpu_din[5:0], addr_q[7:0]};
  assign new_addr_s = VRAM_AW'(hi_lo_s);

  // CPU read path: status byte on the control port, read buffer on the data port.
  always_comb begin
    cpu_dout  = 8'h00;
    status_rd = 1'b0;
    if (cpu_rd) begin
      if (cpu_port) begin
        cpu_dout  = status_in;
        status_rd = idle_s & ~cpu_wr;
      end else begin
        cpu_dout  = rbuf_q;
      end
    end else begin
      cpu_dout  = 8'h00;
      status_rd = 1'b0;
    end
  end

  // Access decode, address/code/flag update and VRAM handshake sequencing.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    code_d       = code_q;
    flag_d       = flag_q;
    rbuf_d       = rbuf_q;
    vaddr_d      = vaddr_q;
    vwdata_d     = vwdata_q;
    reg_we_d     = 1'b0;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    cram_we_d    = 1'b0;
    cram_addr_d  = cram_addr_q;
    cram_wdata_d = cram_wdata_q;
`ifdef GG_CRAM_EN
    latch_d      = latch_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_wr) begin
          if (cpu_port) begin
            if (!flag_q) begin
              // First control byte: low address.
              addr_d[7:0] = cpu_din;
              flag_d      = 1'b1;
            end else begin
              // Second control byte: code and high address.
              flag_d = 1'b0;
              code_d = cpu_din[7:6];
              addr_d = new_addr_s;
              case (cpu_din[7:6])
                2'd0: begin
                  vaddr_d = new_addr_s;
                  addr_d  = new_addr_s + VRAM_AW'(1);
                  state_d = RD_REQ;
                end
                2'd2: begin
                  reg_we_d    = 1'b1;
                  reg_addr_d  = cpu_din[3:0];
                  reg_wdata_d = addr_q[7:0];
                end
                default: begin
                  state_d = IDLE;
                end
              endcase
            end
          end else begin
            flag_d = 1'b0;
            rbuf_d = cpu_din;
            addr_d = addr_inc_s;
            if (code_q == 2'd3) begin
`ifdef GG_CRAM_EN
              // Even byte is held; the odd byte completes the 12-bit word.
              if (!addr_q[0]) begin
                latch_d = cpu_din;
              end else begin
                cram_we_d    = 1'b1;
                cram_addr_d  = addr_q[5:1];
                cram_wdata_d = {cpu_din[3:0], latch_q};
              end
`else
              cram_we_d    = 1'b1;
              cram_addr_d  = addr_q[4:0];
              cram_wdata_d = {6'b000000, cpu_din[5:0]};
`endif
            end else begin
              vaddr_d  = addr_q;
              vwdata_d = cpu_din;
              state_d  = WR_REQ;
            end
          end
        end else if (cpu_rd) begin
          flag_d = 1'b0;
          if (!cpu_port) begin
            vaddr_d = addr_q;
            addr_d  = addr_inc_s;
            state_d = RD_REQ;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        if (vram.vram_grant) begin
          state_d = IDLE;
        end else begin
          state_d = WR_REQ;
        end
      end
      RD_REQ: begin
        if (vram.vram_grant) begin
          state_d = RD_DATA;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_DATA: begin
        state_d = IDLE;
        // A CPU data write landing on the fetch-complete cycle owns the buffer.
        if (cpu_wr && !cpu_port) begin
          rbuf_d = cpu_din;
        end else begin
          rbuf_d = vram.vram_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    vreq_d = (state_d == WR_REQ) || (state_d == RD_REQ);
    vwe_d  = (state_d == WR_REQ);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any pending VRAM request at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      code_q       <= 2'd0;
      flag_q       <= 1'b0;
      rbuf_q       <= 8'h00;
      vaddr_q      <= '0;
      vwdata_q     <= 8'h00;
      vreq_q       <= 1'b0;
      vwe_q        <= 1'b0;
      busy_q       <= 1'b0;
      reg_we_q     <= 1'b0;
      reg_addr_q   <= 4'h0;
      reg_wdata_q  <= 8'h00;
      cram_we_q    <= 1'b0;
      cram_addr_q  <= 5'd0;
      cram_wdata_q <= 12'h000;
`ifdef GG_CRAM_EN
      latch_q      <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      code_q       <= code_d;
      flag_q       <= flag_d;
      rbuf_q       <= rbuf_d;
      vaddr_q      <= vaddr_d;
      vwdata_q     <= vwdata_d;
      vreq_q       <= vreq_d;
      vwe_q        <= vwe_d;
      busy_q       <= busy_d;
      reg_we_q     <= reg_we_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      cram_we_q    <= cram_we_d;
      cram_addr_q  <= cram_addr_d;
      cram_wdata_q <= cram_wdata_d;
`ifdef GG_CRAM_EN
      latch_q      <= latch_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign vram.vram_req   = vreq_q;
  assign vram.vram_we    = vwe_q;
  assign vram.vram_addr  = vaddr_q;
  assign vram.vram_wdata = vwdata_q;
  assign reg_we          = reg_we_q;
  assign reg_addr        = reg_addr_q;
  assign reg_wdata       = reg_wdata_q;
  assign cram_we         = cram_we_q;
  assign cram_addr       = cram_addr_q;
  assign cram_wdata      = cram_wdata_q;

endmodule

// File: doc/vdp_cpu_port.md
Name: vdp_cpu_port

Overview:
CPU-side write/read front end of the VDP. It decodes Z80 accesses to the data port (0xBE) and control port (0xBF) into VRAM writes and read-ahead fetches, CRAM writes, and VDP register writes. It is the producer of the VRAM contents that the background and sprite renderers consume. VRAM access goes through a request/grant handshake with the VRAM arbiter, which gives renderer fetches priority.

Parameters:
VRAM_AW, 14, VRAM byte address width; the address register wraps modulo 2^VRAM_AW.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cpu_wr  in  1  one-cycle write strobe
cpu_rd  in  1  one-cycle read strobe
cpu_port  in  1  0 = data port, 1 = control port
cpu_din  in  8  CPU write data
cpu_dout  out  8  read data: read buffer (data port) or status_in (control port)
busy  out  1  VRAM access pending; CPU wait request
status_in  in  8  VDP status byte
status_rd  out  1  one-cycle pulse when the control port is read (clears status flags)
vram_req  out  1  VRAM access request
vram_grant  in  1  arbiter grant; vram_addr/vram_we are sampled in this cycle
vram_addr  out  VRAM_AW  VRAM byte address
vram_we  out  1  write qualifier (valid with vram_req)
vram_wdata  out  8  VRAM write data
vram_rdata  in  8  VRAM read data, valid the cycle after a read grant
cram_we  out  1  CRAM write pulse
cram_addr  out  5  CRAM word index
cram_wdata  out  12  CRAM word
reg_we  out  1  register write pulse
reg_addr  out  4  register index
reg_wdata  out  8  register value

Behaviour:
- Reset values: all outputs 0; address register 0; code 0; first-byte flag clear; read buffer 0; state IDLE.
- Control write, flag clear: latch cpu_din as addr[7:0]; set flag.
- Control write, flag set: code <= cpu_din[7:6]; addr[13:8] <= cpu_din[5:0]; clear flag. Then by code:
  - Code 0: start a VRAM read-ahead at the new addr.
  - Code 2: pulse reg_we for 1 cycle with reg_addr = cpu_din[3:0] and reg_wdata = the latched low byte. Addr is still updated.
  - Codes 1 and 3: no further action.
- Any data-port access clears the flag. A control-port read also clears the flag.
- Control read: cpu_dout = status_in, combinational. status_rd pulses in the strobe cycle.
- Data write, code 0/1/2: read buffer <= cpu_din. Queue a VRAM write at addr, then addr <= addr+1.
- Data write, code 3: CRAM write (see Optional Feature). Read buffer <= cpu_din; addr <= addr+1; no VRAM access.
- Data read: cpu_dout = read buffer. Then start a read-ahead at addr, addr+1.
- Address increment wraps 0x3FFF -> 0x0000.
- FSM states: IDLE, WR_REQ, RD_REQ, RD_DATA.
  - IDLE -> WR_REQ / RD_REQ on the cycle after the triggering strobe.
  - WR_REQ: vram_req=1, vram_we=1. Hold until vram_grant, then -> IDLE.
  - RD_REQ: vram_req=1, vram_we=0. On grant -> RD_DATA.
  - RD_DATA: read buffer <= vram_rdata, then -> IDLE.
  - busy=1 in every state except IDLE.
- vram_addr and vram_wdata are captured at queue time and stay stable until grant.
- Strobes while busy=1 are ignored; the CPU is required to honour busy.
- A data write that arrives in the cycle RD_DATA completes takes priority over the fetched byte: the read buffer holds cpu_din.
- Simultaneous cpu_wr and cpu_rd: cpu_wr wins; cpu_rd is ignored.
- rst mid-access drops the request immediately; vram_req=0 asynchronously.

Optional Feature:
GG_CRAM_EN defined (Game Gear mode):
- CRAM is 64 bytes, 32 words of 12 bits.
- Data write with even addr: latch cpu_din into a low-byte latch; no pulse.
- Data write with odd addr: pulse cram_we with cram_addr = addr[5:1] and cram_wdata = {cpu_din[3:0], latch}.
Undefined (SMS mode):
- Every code-3 data write pulses cram_we with cram_addr = addr[4:0] and cram_wdata = {6'b0, cpu_din[5:0]}.
- No latch exists.

Test Plan:
- Control 0x00, 0x40, then data 0xAB, 0xCD, grant 2 cycles after each request -> VRAM writes 0x0000=0xAB and 0x0001=0xCD; busy high until each grant; addr ends at 0x0002.
- Control 0x05, 0x81 -> one reg_we pulse, reg_addr=1, reg_wdata=0x05; no vram_req.
- Control 0x10, 0x00 with vram_rdata=0x77 after grant -> read buffer=0x77. Then data read returns 0x77 and the next fetch uses addr 0x0011.
- Control 0xFF, 0x7F, then data write 0x12 -> VRAM 0x3FFF=0x12, addr wraps to 0x0000.
- GG_CRAM_EN: control 0x02, 0xC0, data 0x34, 0x0E -> cram_we once, cram_addr=1, cram_wdata=0xE34. Without the macro: two pulses, addr 2 <- 0x34, addr 3 <- 0x0E.
- Control write 0x22, then control read -> cpu_dout=status_in and status_rd pulse. The next control byte is treated as a first byte (addr low).
